// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    RESP    = 2'd3
  } state_e;

  function automatic int calc_idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int lines);
    return addr_w - $clog2(lines) - 2;
  endfunction

  // Word index: byte-offset bits [1:0] are dropped before masking.
  function automatic logic [63:0] addr_index(input logic [63:0] addr, input int idx_w);
    return (addr >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int idx_w);
    return addr >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: one combinational lookup port, one write port, async valid clear.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int TAG_W  = 26,
  parameter int DATA_W = 32,
  parameter int IDX_W  = calc_idx_w(LINES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [TAG_W-1:0]  rd_tag_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign hit_o     = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache; misses and stores stall the CPU.
module dcache
  import dcache_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output state_e            dbg_state
);

  localparam int IDX_W = calc_idx_w(LINES);
  localparam int TAG_W = calc_tag_w(ADDR_W, LINES);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] resp_q;
  logic              mem_read_q;
  logic              mem_write_q;

  logic [ADDR_W-1:0] lookup_addr;
  logic [IDX_W-1:0]  rd_idx;
  logic [TAG_W-1:0]  rd_tag;
  logic [IDX_W-1:0]  wr_idx;
  logic [TAG_W-1:0]  wr_tag;
  logic              hit;
  logic [DATA_W-1:0] line_data;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

  // Outside IDLE the lookup follows the latched address, so a store's hit test sees its own line.
  assign lookup_addr = (state_q == IDLE) ? cpu_addr : addr_q;
  assign rd_idx      = IDX_W'(addr_index(64'(lookup_addr), IDX_W));
  assign rd_tag      = TAG_W'(addr_tag(64'(lookup_addr), IDX_W));
  assign wr_idx      = IDX_W'(addr_index(64'(addr_q), IDX_W));
  assign wr_tag      = TAG_W'(addr_tag(64'(addr_q), IDX_W));

  assign wr_en   = mem_ack && ((state_q == RD_MISS) || ((state_q == WR_THRU) && hit));
  assign wr_data = (state_q == RD_MISS) ? mem_rdata : wdata_q;

  dcache_array #(
    .LINES (LINES),
    .TAG_W (TAG_W),
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i    (clk),
    .rst_i    (rst),
    .rd_idx_i (rd_idx),
    .rd_tag_i (rd_tag),
    .hit_o    (hit),
    .rd_data_o(line_data),
    .wr_en_i  (wr_en),
    .wr_idx_i (wr_idx),
    .wr_tag_i (wr_tag),
    .wr_data_i(wr_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_write) begin
            addr_q      <= cpu_addr;
            wdata_q     <= cpu_wdata;
            mem_write_q <= 1'b1;
            state_q     <= WR_THRU;
          end else if (cpu_read && !hit) begin
            addr_q     <= cpu_addr;
            mem_read_q <= 1'b1;
            state_q    <= RD_MISS;
          end
        end
        RD_MISS: begin
          if (mem_ack) begin
            resp_q     <= mem_rdata;
            mem_read_q <= 1'b0;
            state_q    <= RESP;
          end
        end
        WR_THRU: begin
          if (mem_ack) begin
            mem_write_q <= 1'b0;
            state_q     <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    case (state_q)
      IDLE: begin
        cpu_stall = cpu_write || (cpu_read && !hit);
        cpu_rdata = hit ? line_data : '0;
      end
      RD_MISS, WR_THRU: cpu_stall = 1'b1;
      RESP:             cpu_rdata = resp_q;
      default: begin
        cpu_stall = 1'b0;
        cpu_rdata = '0;
      end
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign dbg_state = state_q;

endmodule
